// File: rtl/mem_cp0_exception_unit_pkg.sv
// Shared CP0 constants, Status bit positions, FSM states and event kinds
// for the MEM-stage CP0 forwarding and exception unit.
package mem_cp0_exception_unit_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // MTC0 to Cause may only touch the software IP bits (9:8), IV (23) and WP (22)
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_INT  = 2'd2,
    EV_ERET = 2'd3
  } exc_event_t;

  function automatic logic [4:0] exc_code_of(input exc_event_t ev, input logic [4:0] code);
    return (ev == EV_EXC) ? code : EXC_INT;
  endfunction

endpackage

// File: rtl/mem_cp0_exception_unit_if.sv
// Pipeline-side bundle of the CP0 exception unit: architectural CP0 values,
// MTC0 write port, MEM-stage events, interrupts and the flush/commit/redirect results.
interface mem_cp0_exception_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IRQ_LINES  = 6
);
  logic [DATA_WIDTH-1:0] cp0_status;
  logic [DATA_WIDTH-1:0] cp0_cause;
  logic [DATA_WIDTH-1:0] cp0_epc;
  logic                  wr_valid;
  logic [4:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  mem_exc_valid;
  logic [4:0]            mem_exc_code;
  logic                  mem_eret;
  logic [DATA_WIDTH-1:0] mem_pc;
  logic [IRQ_LINES-1:0]  irq;

  logic [DATA_WIDTH-1:0] status_fwd;
  logic [DATA_WIDTH-1:0] cause_fwd;
  logic [DATA_WIDTH-1:0] epc_fwd;
  logic                  force_disable_mem;
  logic                  flush;
  logic                  commit_valid;
  logic [DATA_WIDTH-1:0] commit_epc;
  logic [DATA_WIDTH-1:0] commit_status;
  logic [DATA_WIDTH-1:0] commit_cause;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;

  modport master (
    output cp0_status, cp0_cause, cp0_epc, wr_valid, wr_addr, wr_data,
           mem_exc_valid, mem_exc_code, mem_eret, mem_pc, irq,
    input  status_fwd, cause_fwd, epc_fwd, force_disable_mem, flush,
           commit_valid, commit_epc, commit_status, commit_cause,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  cp0_status, cp0_cause, cp0_epc, wr_valid, wr_addr, wr_data,
           mem_exc_valid, mem_exc_code, mem_eret, mem_pc, irq,
    output status_fwd, cause_fwd, epc_fwd, force_disable_mem, flush,
           commit_valid, commit_epc, commit_status, commit_cause,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/mem_cp0_exception_unit_cp0_fwd_buffer.sv
// cp0_fwd_buffer: shift history of in-flight MTC0 writes and youngest-wins
// forwarding of Status, Cause (masked) and EPC.
module cp0_fwd_buffer
  import mem_cp0_exception_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FWD_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] cp0_status,
  input  logic [DATA_WIDTH-1:0] cp0_cause,
  input  logic [DATA_WIDTH-1:0] cp0_epc,
  output logic [DATA_WIDTH-1:0] status_fwd,
  output logic [DATA_WIDTH-1:0] cause_fwd,
  output logic [DATA_WIDTH-1:0] epc_fwd
);

  localparam logic [DATA_WIDTH-1:0] CAUSE_MASK = DATA_WIDTH'(CAUSE_WR_MASK);

  logic [FWD_DEPTH-1:0]  valid_reg;
  logic [4:0]            addr_reg [FWD_DEPTH];
  logic [DATA_WIDTH-1:0] data_reg [FWD_DEPTH];

  logic [FWD_DEPTH-1:0]  hit_status;
  logic [FWD_DEPTH-1:0]  hit_cause;
  logic [FWD_DEPTH-1:0]  hit_epc;

  // Entry 0 is the youngest; an idle cycle shifts in a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) begin
        addr_reg[i] <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg[0] <= wr_valid;
      addr_reg[0]  <= wr_addr;
      data_reg[0]  <= wr_data;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        addr_reg[i]  <= addr_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_hit
      assign hit_status[gi] = valid_reg[gi] && (addr_reg[gi] == CP0_STATUS);
      assign hit_cause[gi]  = valid_reg[gi] && (addr_reg[gi] == CP0_CAUSE);
      assign hit_epc[gi]    = valid_reg[gi] && (addr_reg[gi] == CP0_EPC);
    end
  endgenerate

  // Walk oldest to youngest so later matches override earlier ones.
  always_comb begin
    status_fwd = cp0_status;
    cause_fwd  = cp0_cause;
    epc_fwd    = cp0_epc;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (hit_status[i]) status_fwd = data_reg[i];
      if (hit_cause[i])  cause_fwd  = (cause_fwd & ~CAUSE_MASK) | (data_reg[i] & CAUSE_MASK);
      if (hit_epc[i])    epc_fwd    = data_reg[i];
    end
    if (wr_valid) begin
      if (wr_addr == CP0_STATUS) status_fwd = wr_data;
      if (wr_addr == CP0_CAUSE)  cause_fwd  = (cause_fwd & ~CAUSE_MASK) | (wr_data & CAUSE_MASK);
      if (wr_addr == CP0_EPC)    epc_fwd    = wr_data;
    end
  end

endmodule

// File: rtl/mem_cp0_exception_unit.sv
// MEM-stage CP0 forwarding plus IDLE/FLUSH/REDIRECT exception sequencer.
// Hardware interrupts are only sequenced when CP0_INTERRUPT_EN is defined.
module mem_cp0_exception_unit
  import mem_cp0_exception_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FWD_DEPTH  = 2,
  parameter int                    IRQ_LINES  = 6,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = DATA_WIDTH'(32'hBFC0_0380)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_cp0_exception_unit_if.slave bus
);

  logic [DATA_WIDTH-1:0] status_fwd;
  logic [DATA_WIDTH-1:0] cause_fwd;
  logic [DATA_WIDTH-1:0] epc_fwd;

  cp0_fwd_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .FWD_DEPTH  (FWD_DEPTH)
  ) u_fwd (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (bus.wr_valid),
    .wr_addr    (bus.wr_addr),
    .wr_data    (bus.wr_data),
    .cp0_status (bus.cp0_status),
    .cp0_cause  (bus.cp0_cause),
    .cp0_epc    (bus.cp0_epc),
    .status_fwd (status_fwd),
    .cause_fwd  (cause_fwd),
    .epc_fwd    (epc_fwd)
  );

  logic int_pending;

`ifdef CP0_INTERRUPT_EN
  logic [IRQ_LINES-1:0] irq_meta_reg;
  logic [IRQ_LINES-1:0] irq_sync_reg;
  logic [7:0]           hw_ip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_meta_reg <= '0;
      irq_sync_reg <= '0;
    end else begin
      irq_meta_reg <= bus.irq;
      irq_sync_reg <= irq_meta_reg;
    end
  end

  // Hardware lines land on IP2..IP7; IP1:IP0 are the software bits from Cause.
  assign hw_ip[1:0] = 2'b00;
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_hw_ip
      if (gi < IRQ_LINES) begin : g_line
        assign hw_ip[gi+2] = irq_sync_reg[gi];
      end else begin : g_none
        assign hw_ip[gi+2] = 1'b0;
      end
    end
  endgenerate

  assign int_pending = status_fwd[STATUS_IE] && !status_fwd[STATUS_EXL] &&
                       (|((cause_fwd[15:8] | hw_ip) & status_fwd[STATUS_IM_HI:STATUS_IM_LO]));
`else
  logic unused_irq;
  assign unused_irq  = ^bus.irq;
  assign int_pending = 1'b0;
`endif

  exc_state_t            state_reg;
  exc_event_t            event_now;
  logic                  flush_reg;
  logic                  fdm_reg;
  logic                  commit_valid_reg;
  logic                  redirect_valid_reg;
  logic [DATA_WIDTH-1:0] commit_epc_reg;
  logic [DATA_WIDTH-1:0] commit_status_reg;
  logic [DATA_WIDTH-1:0] commit_cause_reg;
  logic [DATA_WIDTH-1:0] target_reg;
  logic [DATA_WIDTH-1:0] redirect_pc_reg;

  logic [DATA_WIDTH-1:0] cap_epc;
  logic [DATA_WIDTH-1:0] cap_status;
  logic [DATA_WIDTH-1:0] cap_cause;
  logic [DATA_WIDTH-1:0] cap_target;

  // Events are only seen in IDLE; anything arriving later belongs to flushed work.
  always_comb begin
    event_now = EV_NONE;
    if (state_reg == ST_IDLE) begin
      if (bus.mem_exc_valid) event_now = EV_EXC;
      else if (int_pending)  event_now = EV_INT;
      else if (bus.mem_eret) event_now = EV_ERET;
    end
  end

  always_comb begin
    cap_epc                = bus.mem_pc;
    cap_status             = status_fwd;
    cap_status[STATUS_EXL] = 1'b1;
    cap_cause              = cause_fwd;
    cap_cause[6:2]         = exc_code_of(event_now, bus.mem_exc_code);
    cap_target             = EXC_VECTOR;
    if (event_now == EV_ERET) begin
      cap_epc                = epc_fwd;
      cap_status             = status_fwd;
      cap_status[STATUS_EXL] = 1'b0;
      cap_cause              = cause_fwd;
      cap_target             = epc_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      flush_reg          <= 1'b0;
      fdm_reg            <= 1'b0;
      commit_valid_reg   <= 1'b0;
      redirect_valid_reg <= 1'b0;
      commit_epc_reg     <= '0;
      commit_status_reg  <= '0;
      commit_cause_reg   <= '0;
      target_reg         <= '0;
      redirect_pc_reg    <= '0;
    end else begin
      flush_reg          <= 1'b0;
      fdm_reg            <= 1'b0;
      commit_valid_reg   <= 1'b0;
      redirect_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (event_now != EV_NONE) begin
            state_reg         <= ST_FLUSH;
            flush_reg         <= 1'b1;
            fdm_reg           <= 1'b1;
            commit_valid_reg  <= 1'b1;
            commit_epc_reg    <= cap_epc;
            commit_status_reg <= cap_status;
            commit_cause_reg  <= cap_cause;
            target_reg        <= cap_target;
          end
        end
        ST_FLUSH: begin
          state_reg          <= ST_REDIRECT;
          redirect_valid_reg <= 1'b1;
          redirect_pc_reg    <= target_reg;
        end
        ST_REDIRECT: state_reg <= ST_IDLE;
        default:     state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.status_fwd        = status_fwd;
  assign bus.cause_fwd         = cause_fwd;
  assign bus.epc_fwd           = epc_fwd;
  assign bus.force_disable_mem = fdm_reg || (event_now != EV_NONE);
  assign bus.flush             = flush_reg;
  assign bus.commit_valid      = commit_valid_reg;
  assign bus.commit_epc        = commit_epc_reg;
  assign bus.commit_status     = commit_status_reg;
  assign bus.commit_cause      = commit_cause_reg;
  assign bus.redirect_valid    = redirect_valid_reg;
  assign bus.redirect_pc       = redirect_pc_reg;

endmodule

// File: tb/tb_mem_cp0_exception_unit.sv
// Randomized and directed bench for mem_cp0_exception_unit against a
// write-history / phase-counter reference model.
module tb_mem_cp0_exception_unit;

  localparam int          DW         = 32;
  localparam int          FWD_DEPTH  = 2;
  localparam int          IRQ_LINES  = 6;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_cp0_exception_unit_if #(.DATA_WIDTH(DW), .IRQ_LINES(IRQ_LINES)) bus_if ();

  mem_cp0_exception_unit #(
    .DATA_WIDTH (DW),
    .FWD_DEPTH  (FWD_DEPTH),
    .IRQ_LINES  (IRQ_LINES),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         hist[$];           // front = most recent cycle
  int          phase;             // cycles since accepted event: 0 idle, 1 flush, 2 redirect
  logic [31:0] m_cepc, m_cstat, m_ccause, m_rpc, pend_target;
`ifdef CP0_INTERRUPT_EN
  logic [IRQ_LINES-1:0] irq_dly [2];
`endif

  task automatic reset_model();
    wr_t bub;
    bub.v = 1'b0; bub.a = '0; bub.d = '0;
    hist.delete();
    for (int i = 0; i < FWD_DEPTH; i++) hist.push_back(bub);
    phase = 0;
    m_cepc = '0; m_cstat = '0; m_ccause = '0; m_rpc = '0; pend_target = '0;
`ifdef CP0_INTERRUPT_EN
    irq_dly[0] = '0; irq_dly[1] = '0;
`endif
  endtask

  task automatic fwd_apply(input logic [4:0] a, input logic [31:0] d,
                           inout logic [31:0] s, inout logic [31:0] c, inout logic [31:0] e);
    if (a == 5'd12) s = d;
    if (a == 5'd13) begin
      c[9:8] = d[9:8];
      c[22]  = d[22];
      c[23]  = d[23];
    end
    if (a == 5'd14) e = d;
  endtask

  initial begin : compare_proc
    logic [31:0] s, c, e;
    logic        pend, is_exc, is_int, is_eret;
    wr_t         w;
    reset_model();
    @(posedge clk);
    forever begin
      @(negedge clk);
      s = bus_if.cp0_status; c = bus_if.cp0_cause; e = bus_if.cp0_epc;
      for (int i = hist.size() - 1; i >= 0; i--)
        if (hist[i].v) fwd_apply(hist[i].a, hist[i].d, s, c, e);
      if (bus_if.wr_valid) fwd_apply(bus_if.wr_addr, bus_if.wr_data, s, c, e);

      pend = 1'b0;
`ifdef CP0_INTERRUPT_EN
      pend = s[0] && !s[1] && (((c[15:8] | 8'({irq_dly[1], 2'b00})) & s[15:8]) != 8'h00);
`endif
      is_exc  = (phase == 0) && bus_if.mem_exc_valid;
      is_int  = (phase == 0) && !bus_if.mem_exc_valid && pend;
      is_eret = (phase == 0) && !bus_if.mem_exc_valid && !pend && bus_if.mem_eret;

      check("status_fwd", bus_if.status_fwd, s);
      check("cause_fwd", bus_if.cause_fwd, c);
      check("epc_fwd", bus_if.epc_fwd, e);
      check("force_disable_mem", 32'(bus_if.force_disable_mem), 32'(is_exc || is_int || is_eret || phase == 1));
      check("flush", 32'(bus_if.flush), 32'(phase == 1));
      check("commit_valid", 32'(bus_if.commit_valid), 32'(phase == 1));
      check("redirect_valid", 32'(bus_if.redirect_valid), 32'(phase == 2));
      check("commit_epc", bus_if.commit_epc, m_cepc);
      check("commit_status", bus_if.commit_status, m_cstat);
      check("commit_cause", bus_if.commit_cause, m_ccause);
      check("redirect_pc", bus_if.redirect_pc, m_rpc);

      if (!rst_n) begin
        reset_model();
      end else begin
        w.v = bus_if.wr_valid; w.a = bus_if.wr_addr; w.d = bus_if.wr_data;
        hist.push_front(w);
        void'(hist.pop_back());
`ifdef CP0_INTERRUPT_EN
        irq_dly[1] = irq_dly[0];
        irq_dly[0] = bus_if.irq;
`endif
        if (phase == 2) begin
          phase = 0;
        end else if (phase == 1) begin
          phase = 2;
          m_rpc = pend_target;
        end else if (is_exc || is_int) begin
          phase       = 1;
          m_cepc      = bus_if.mem_pc;
          m_ccause    = c;
          m_ccause[6:2] = is_exc ? bus_if.mem_exc_code : 5'd0;
          m_cstat     = s | 32'h2;
          pend_target = EXC_VECTOR;
        end else if (is_eret) begin
          phase       = 1;
          m_cepc      = e;
          m_ccause    = c;
          m_cstat     = s & ~32'h2;
          pend_target = e;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.cp0_status = '0; bus_if.cp0_cause = '0; bus_if.cp0_epc = '0;
    bus_if.wr_valid = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
    bus_if.mem_exc_valid = 1'b0; bus_if.mem_exc_code = '0; bus_if.mem_eret = 1'b0;
    bus_if.mem_pc = '0; bus_if.irq = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin : stim_proc
    int          n_commit, n_flush;
    logic [31:0] epc_seen, code_seen;
    int          exp_int;

`ifdef CP0_INTERRUPT_EN
    exp_int = 1;
`else
    exp_int = 0;
`endif

    clear_inputs();
    bus_if.cp0_status = 32'h0000_1234;
    rst_n = 1'b0;
    idle(2);
    #1;
    $display("[TB] reset");
    check("reset_commit_valid", 32'(bus_if.commit_valid), 32'h0);
    check("reset_redirect_pc", bus_if.redirect_pc, 32'h0);
    check("reset_commit_epc", bus_if.commit_epc, 32'h0);
    check("reset_status_fwd", bus_if.status_fwd, 32'h0000_1234);
    rst_n = 1'b1;
    bus_if.cp0_status = '0;
    cycle();

    $display("[TB] forward status write");
    bus_if.wr_valid = 1'b1; bus_if.wr_addr = 5'd12; bus_if.wr_data = 32'h0000_FF01;
    #1 check("fwd_same_cycle", bus_if.status_fwd, 32'h0000_FF01);
    cycle();
    bus_if.wr_valid = 1'b0;
    for (int i = 1; i <= FWD_DEPTH; i++) begin
      #1 check("fwd_held", bus_if.status_fwd, 32'h0000_FF01);
      cycle();
    end
    #1 check("fwd_expired", bus_if.status_fwd, 32'h0);

    $display("[TB] cause write mask");
    bus_if.wr_valid = 1'b1; bus_if.wr_addr = 5'd13; bus_if.wr_data = 32'hFFFF_FFFF;
    #1 check("cause_mask", bus_if.cause_fwd, 32'h00C0_0300);
    cycle();
    bus_if.wr_valid = 1'b0;
    idle(FWD_DEPTH + 1);

    $display("[TB] exception code 4 at 0x1000");
    bus_if.mem_exc_valid = 1'b1; bus_if.mem_exc_code = 5'd4; bus_if.mem_pc = 32'h0000_1000;
    #1 check("exc_fdm_T", 32'(bus_if.force_disable_mem), 32'h1);
    cycle();
    bus_if.mem_exc_code = 5'd7; bus_if.mem_pc = 32'h0000_9999;
    #1;
    check("exc_flush_T1", 32'(bus_if.flush), 32'h1);
    check("exc_commit_valid_T1", 32'(bus_if.commit_valid), 32'h1);
    check("exc_commit_epc", bus_if.commit_epc, 32'h0000_1000);
    check("exc_commit_code", 32'(bus_if.commit_cause[6:2]), 32'h4);
    check("exc_commit_exl", 32'(bus_if.commit_status[1]), 32'h1);
    cycle();
    bus_if.mem_exc_valid = 1'b0;
    #1;
    check("exc_redirect_valid_T2", 32'(bus_if.redirect_valid), 32'h1);
    check("exc_redirect_pc", bus_if.redirect_pc, EXC_VECTOR);
    cycle();
    #1;
    check("exc_second_ignored", 32'(bus_if.flush), 32'h0);
    check("exc_commit_epc_hold", bus_if.commit_epc, 32'h0000_1000);
    idle(1);

    $display("[TB] exception with eret at 0x2000");
    bus_if.mem_exc_valid = 1'b1; bus_if.mem_exc_code = 5'd5; bus_if.mem_eret = 1'b1;
    bus_if.mem_pc = 32'h0000_2000; bus_if.cp0_epc = 32'h0000_3000;
    cycle();
    bus_if.mem_exc_valid = 1'b0; bus_if.mem_eret = 1'b0;
    #1;
    check("arb_commit_epc", bus_if.commit_epc, 32'h0000_2000);
    check("arb_commit_code", 32'(bus_if.commit_cause[6:2]), 32'h5);
    cycle();
    #1 check("arb_redirect_pc", bus_if.redirect_pc, EXC_VECTOR);
    idle(2);

    $display("[TB] eret to 0x4000");
    bus_if.cp0_status = 32'h0000_0003; bus_if.cp0_epc = 32'h0000_4000; bus_if.mem_eret = 1'b1;
    #1 check("eret_fdm_T", 32'(bus_if.force_disable_mem), 32'h1);
    cycle();
    bus_if.mem_eret = 1'b0;
    #1;
    check("eret_commit_status", bus_if.commit_status, 32'h0000_0001);
    check("eret_commit_epc", bus_if.commit_epc, 32'h0000_4000);
    cycle();
    #1 check("eret_redirect_pc", bus_if.redirect_pc, 32'h0000_4000);
    cycle();
    bus_if.cp0_status = '0; bus_if.cp0_epc = '0;
    idle(1);

    $display("[TB] irq0 with IE=1 EXL=0");
    bus_if.cp0_status = 32'h0000_0401; bus_if.mem_pc = 32'h0000_5000; bus_if.irq = 6'b000001;
    n_commit = 0; epc_seen = '0; code_seen = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k == 2) bus_if.irq = '0;
      #1;
      if (bus_if.commit_valid) begin
        n_commit++;
        epc_seen  = bus_if.commit_epc;
        code_seen = 32'(bus_if.commit_cause[6:2]);
      end
    end
    check("int_commit_count", 32'(n_commit), 32'(exp_int));
    check("int_commit_epc", epc_seen, (exp_int != 0) ? 32'h0000_5000 : 32'h0);
    check("int_commit_code", code_seen, 32'h0);

    $display("[TB] irq0 with EXL=1");
    bus_if.cp0_status = 32'h0000_0403; bus_if.irq = 6'b000001;
    n_flush = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k == 2) bus_if.irq = '0;
      #1;
      if (bus_if.flush) n_flush++;
    end
    check("int_exl_no_flush", 32'(n_flush), 32'h0);
    clear_inputs();
    idle(2);

    $display("[TB] reset during flush");
    bus_if.mem_exc_valid = 1'b1; bus_if.mem_exc_code = 5'd4; bus_if.mem_pc = 32'h0000_6000;
    cycle();
    bus_if.mem_exc_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("rst_mid_in_flush", 32'(bus_if.flush), 32'h1);
    cycle();
    rst_n = 1'b1;
    #1;
    check("rst_mid_commit_valid", 32'(bus_if.commit_valid), 32'h0);
    check("rst_mid_flush", 32'(bus_if.flush), 32'h0);
    check("rst_mid_fdm", 32'(bus_if.force_disable_mem), 32'h0);
    check("rst_mid_commit_epc", bus_if.commit_epc, 32'h0);
    check("rst_mid_commit_status", bus_if.commit_status, 32'h0);
    check("rst_mid_redirect_pc", bus_if.redirect_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1 check("rst_mid_no_redirect", 32'(bus_if.redirect_valid), 32'h0);
      cycle();
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      bus_if.wr_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       bus_if.wr_addr = 5'd12;
        1:       bus_if.wr_addr = 5'd13;
        2:       bus_if.wr_addr = 5'd14;
        default: bus_if.wr_addr = 5'($urandom_range(0, 31));
      endcase
      bus_if.wr_data       = $urandom;
      bus_if.cp0_status    = $urandom;
      bus_if.cp0_cause     = $urandom;
      bus_if.cp0_epc       = $urandom;
      bus_if.mem_pc        = $urandom;
      bus_if.mem_exc_valid = ($urandom_range(0, 9) == 0);
      bus_if.mem_exc_code  = 5'($urandom_range(0, 31));
      bus_if.mem_eret      = ($urandom_range(0, 7) == 0);
      bus_if.irq           = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      rst_n                = ($urandom_range(0, 99) != 0);
      cycle();
    end

    clear_inputs();
    rst_n = 1'b1;
    idle(3);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
